// File: rtl/sargantana_icache_refill_unit.sv
// Purpose : icache line refill engine; issues one line fill to L2, assembles the
//           returned beats into a line and forwards L2 invalidations to the icache.
// Latency : request -> l2_req_valid_o next cycle; last beat -> resp_valid_o next cycle;
//           invalidation -> inv_valid_o next cycle (one more if it collides with a resp).
// Backpressure: one fill in flight (req_ready_o only in IDLE); L2 request held until
//           l2_req_ready_i; 1-entry invalidation buffer, l2_inv_ready_o = buffer empty.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_*                             fill request from icache (paddr, way)
//   kill_i                            core kill of the in-flight fetch
//   resp_valid_o/resp_data_o/resp_way_o   single-cycle assembled line response
//   inv_valid_o/inv_paddr_o           invalidation towards the icache
//   l2_req_*                          line-aligned request to L2
//   l2_beat_*                         in-order data beats from L2
//   l2_inv_*                          invalidation from L2
//   busy_o                            not idle
//   proto_err_o                       sticky: beat seen outside COLLECT
module sargantana_icache_refill_unit #(
  parameter int PADDR_W = 40,
  parameter int LINE_W  = 512,
  parameter int BEAT_W  = 128,
  parameter int WAY_W   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [PADDR_W-1:0] req_paddr_i,
  input  logic [WAY_W-1:0]   req_way_i,
  input  logic               kill_i,
  output logic               resp_valid_o,
  output logic [LINE_W-1:0]  resp_data_o,
  output logic [WAY_W-1:0]   resp_way_o,
  output logic               inv_valid_o,
  output logic [PADDR_W-1:0] inv_paddr_o,
  output logic               l2_req_valid_o,
  input  logic               l2_req_ready_i,
  output logic [PADDR_W-1:0] l2_req_paddr_o,
  input  logic               l2_beat_valid_i,
  input  logic [BEAT_W-1:0]  l2_beat_data_i,
  input  logic               l2_inv_valid_i,
  output logic               l2_inv_ready_o,
  input  logic [PADDR_W-1:0] l2_inv_paddr_i,
  output logic               busy_o,
  output logic               proto_err_o
);

  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [PADDR_W-1:0] LINE_MASK = {{(PADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(NBEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COLLECT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic [PADDR_W-1:0] paddr_q;
  logic [WAY_W-1:0]   way_q;
  logic [LINE_W-1:0]  line_q;
  logic               inv_full_q;
  logic [PADDR_W-1:0] inv_paddr_q;
  logic               proto_err_q;

  logic               req_acc;
  logic               beat_acc;
  logic               last_beat;
  logic               inv_acc;
  logic               inv_hit;

  assign req_acc   = req_valid_i & (state_q == S_IDLE);
  assign beat_acc  = l2_beat_valid_i & (state_q == S_COLLECT);
  assign last_beat = beat_acc & (beat_cnt_q == LAST_BEAT);
  assign inv_acc   = l2_inv_valid_i & ~inv_full_q;
  // An invalidation of the line being filled makes the collected data stale.
  assign inv_hit   = inv_acc & ((l2_inv_paddr_i & LINE_MASK) == paddr_q) &
                     ((state_q == S_COLLECT) | (state_q == S_RESP));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      S_IDLE: begin
        if (req_acc) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end
      end
      S_REQ: begin
        if (l2_req_ready_i) begin
          state_d = S_COLLECT;
          // Request already left for L2: its beats must still be drained.
          if (kill_i) drop_d = 1'b1;
        end else if (kill_i) begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (kill_i | inv_hit) drop_d = 1'b1;
        if (last_beat) state_d = (drop_d) ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (inv_hit) drop_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o    = (state_q == S_IDLE);
    busy_o         = (state_q != S_IDLE);
    l2_req_valid_o = (state_q == S_REQ);
    resp_valid_o   = (state_q == S_RESP) & ~drop_q & ~kill_i & ~inv_hit;
    // The response owns the icache write port; a pending inv waits one cycle.
    inv_valid_o    = inv_full_q & ~resp_valid_o;
    l2_inv_ready_o = ~inv_full_q;
  end

  assign l2_req_paddr_o = paddr_q;
  assign resp_data_o    = line_q;
  assign resp_way_o     = way_q;
  assign inv_paddr_o    = inv_paddr_q;
  assign proto_err_o    = proto_err_q;

  // Fill datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      paddr_q    <= '0;
      way_q      <= '0;
      beat_cnt_q <= '0;
      line_q     <= '0;
    end else begin
      if (req_acc) begin
        paddr_q <= req_paddr_i & LINE_MASK;
        way_q   <= req_way_i;
      end
      if (state_q == S_REQ && l2_req_ready_i) begin
        beat_cnt_q <= '0;
      end else if (beat_acc) begin
        beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
        for (int b = 0; b < NBEATS; b++) begin
          if (beat_cnt_q == CNT_W'(b)) line_q[b*BEAT_W +: BEAT_W] <= l2_beat_data_i;
        end
      end
    end
  end

  // Invalidation buffer and protocol error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inv_full_q  <= 1'b0;
      inv_paddr_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (inv_acc) begin
        inv_full_q  <= 1'b1;
        inv_paddr_q <= l2_inv_paddr_i;
      end else if (inv_valid_o) begin
        inv_full_q  <= 1'b0;
      end
      if (l2_beat_valid_i && state_q != S_COLLECT) proto_err_q <= 1'b1;
    end
  end

endmodule
